// File: rtl/noc_multi_port_collector.sv
// ----------------------------------------------------------------------------
// noc_multi_port_collector
//
// Packet sink for NUM_CH router local-port links. A round-robin arbiter picks
// one requesting link per accepted packet and captures its header word. The
// header is decoded into packet ID, sender ID and injection timestamp, and the
// network latency is computed against the free-running cycle counter. Result
// records go into a first-word-fall-through FIFO for the log/checker side,
// and running statistics (packet count, maximum latency) are kept.
//
// Ports
//   clk          clock
//   reset        asynchronous, active-low reset
//   packet_in    per-channel header word, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_up       per-channel request (level)
//   gnt_up       per-channel one-hot grant pulse, one cycle per accepted packet
//   up_full      per-channel full indication (all bits equal)
//   rec_valid    record FIFO head valid
//   rec_ready    consumer pops the head when rec_valid & rec_ready
//   rec_pkt_id   head packet ID
//   rec_src      head sender ID
//   rec_ch       head arrival channel
//   rec_latency  head latency
//   clear_stats  synchronous clear of pkt_count and max_latency
//   pkt_count    accepted packets, saturating
//   max_latency  largest latency accepted
//   cycle_count  free-running cycle counter (time base)
// ----------------------------------------------------------------------------
module noc_multi_port_collector #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CH_W       = 2,
    parameter int unsigned SRC_W      = 6,
    parameter int unsigned TS_W       = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH*DATA_WIDTH-1:0] packet_in,
    input  logic [NUM_CH-1:0]            req_up,
    output logic [NUM_CH-1:0]            gnt_up,
    output logic [NUM_CH-1:0]            up_full,
    output logic                         rec_valid,
    input  logic                         rec_ready,
    output logic [9:0]                   rec_pkt_id,
    output logic [SRC_W-1:0]             rec_src,
    output logic [CH_W-1:0]              rec_ch,
    output logic [TS_W-1:0]              rec_latency,
    input  logic                         clear_stats,
    output logic [31:0]                  pkt_count,
    output logic [TS_W-1:0]              max_latency,
    output logic [31:0]                  cycle_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned REC_W = 10 + SRC_W + CH_W + TS_W;

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_e;

    state_e              r_state;
    logic [NUM_CH-1:0]   r_gnt;
    logic [CH_W-1:0]     r_rr_last;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [REC_W-1:0]    r_mem [FIFO_DEPTH];
    logic [31:0]         r_pkt_count;
    logic [TS_W-1:0]     r_max_lat;
    logic [31:0]         r_cycle_count;

    logic                w_found;
    logic [CH_W-1:0]     w_sel;
    logic [CH_W-1:0]     w_cand;
    logic [DATA_WIDTH-1:0] w_word;
    logic [9:0]          w_pkt_id;
    logic [TS_W-1:0]     w_ts;
    logic [SRC_W-1:0]    w_src;
    logic [TS_W-1:0]     w_lat;
    logic [REC_W-1:0]    w_rec_new;
    logic [REC_W-1:0]    w_head;
    logic                w_full;
    logic                w_push;
    logic                w_pop;

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            w_cand = CH_W'((32'(r_rr_last) + i) % NUM_CH);
            if (!w_found && req_up[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    assign w_word    = packet_in[w_sel*DATA_WIDTH +: DATA_WIDTH];
    assign w_pkt_id  = w_word[DATA_WIDTH-1 -: 10];
    assign w_ts      = w_word[SRC_W+TS_W-1:SRC_W];
    assign w_src     = w_word[SRC_W-1:0];
    // Modular subtraction keeps the latency correct across timestamp wrap.
    assign w_lat     = r_cycle_count[TS_W-1:0] - w_ts;
    assign w_rec_new = {w_pkt_id, w_src, w_sel, w_lat};

    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign rec_valid = (r_count != '0);
    // Push is judged on the pre-pop count, so a pop while full only frees the
    // slot; the waiting request is accepted on the following cycle.
    assign w_push    = (r_state == StIdle) && w_found && !w_full;
    assign w_pop     = rec_valid && rec_ready;

    assign w_head      = r_mem[r_rd_ptr];
    assign rec_pkt_id  = w_head[REC_W-1 -: 10];
    assign rec_src     = w_head[CH_W+TS_W +: SRC_W];
    assign rec_ch      = w_head[TS_W +: CH_W];
    assign rec_latency = w_head[TS_W-1:0];

    assign up_full     = {NUM_CH{w_full}};
    assign gnt_up      = r_gnt;
    assign pkt_count   = r_pkt_count;
    assign max_latency = r_max_lat;
    assign cycle_count = r_cycle_count;

    // Arbitration FSM with registered grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= StIdle;
            r_gnt     <= '0;
            r_rr_last <= CH_W'(NUM_CH - 1);
        end else begin
            r_gnt <= '0;
            case (r_state)
                StIdle: begin
                    if (w_push) begin
                        r_gnt     <= NUM_CH'(1) << w_sel;
                        r_rr_last <= w_sel;
                        r_state   <= StGrant;
                    end
                end
                StGrant: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Record storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_rec_new;
        end
    end

    // Statistics; a push coincident with a clear is counted after the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pkt_count <= '0;
            r_max_lat   <= '0;
        end else if (clear_stats) begin
            r_pkt_count <= w_push ? 32'd1 : 32'd0;
            r_max_lat   <= w_push ? w_lat : '0;
        end else if (w_push) begin
            if (r_pkt_count != 32'hFFFF_FFFF) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
            if (w_lat > r_max_lat) begin
                r_max_lat <= w_lat;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle_count <= '0;
        end else begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_noc_multi_port_collector.sv
// ----------------------------------------------------------------------------
// tb_noc_multi_port_collector
//
// Self-checking bench for noc_multi_port_collector with default parameters.
// A queue-based reference model predicts grants, records and statistics each
// cycle; directed steps cover the documented scenarios, followed by a
// randomized traffic phase.
// ----------------------------------------------------------------------------
module tb_noc_multi_port_collector;

    localparam int NUM_CH = 4;
    localparam int DW     = 32;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NUM_CH*DW-1:0] packet_in = '0;
    logic [NUM_CH-1:0] req_up = '0;
    logic [NUM_CH-1:0] gnt_up;
    logic [NUM_CH-1:0] up_full;
    logic              rec_valid;
    logic              rec_ready = 1'b0;
    logic [9:0]        rec_pkt_id;
    logic [5:0]        rec_src;
    logic [1:0]        rec_ch;
    logic [15:0]       rec_latency;
    logic              clear_stats = 1'b0;
    logic [31:0]       pkt_count;
    logic [15:0]       max_latency;
    logic [31:0]       cycle_count;

    noc_multi_port_collector dut (
        .clk         (clk),
        .reset       (reset),
        .packet_in   (packet_in),
        .req_up      (req_up),
        .gnt_up      (gnt_up),
        .up_full     (up_full),
        .rec_valid   (rec_valid),
        .rec_ready   (rec_ready),
        .rec_pkt_id  (rec_pkt_id),
        .rec_src     (rec_src),
        .rec_ch      (rec_ch),
        .rec_latency (rec_latency),
        .clear_stats (clear_stats),
        .pkt_count   (pkt_count),
        .max_latency (max_latency),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned id;
        int unsigned src;
        int unsigned ch;
        int unsigned lat;
    } rec_t;

    rec_t        q[$];
    logic [31:0] m_cyc;
    logic [31:0] m_cnt;
    logic [15:0] m_max;
    int          m_last;
    bit          m_busy;
    logic [3:0]  m_gnt;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int unsigned id, input int unsigned ts,
                                       input int unsigned src);
        logic [31:0] w;
        w = {id[9:0], ts[15:0], src[5:0]};
        return w;
    endfunction

    function automatic int gnt_idx(input logic [3:0] g);
        int r;
        r = -1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (g[i]) r = i;
        end
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        m_cyc  = 0;
        m_cnt  = 0;
        m_max  = 0;
        m_last = NUM_CH - 1;
        m_busy = 1'b0;
        m_gnt  = '0;
    endtask

    task automatic rand_packets();
        for (int c = 0; c < NUM_CH; c++) begin
            packet_in[c*DW +: DW] = $urandom();
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_gnt"}, 32'(gnt_up), 0);
        chk({tag, "_full"}, 32'(up_full), 0);
        chk({tag, "_valid"}, 32'(rec_valid), 0);
        chk({tag, "_pkt_count"}, pkt_count, 0);
        chk({tag, "_max_lat"}, 32'(max_latency), 0);
        chk({tag, "_cycle"}, cycle_count, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check_reset_state("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    // One clock: predict from the current inputs, step, then compare.
    task automatic tick();
        bit          acc;
        bit          pop;
        bit          clr;
        int          sel;
        int          c;
        logic [31:0] w;
        logic [15:0] lat;
        rec_t        r;
        acc = 1'b0;
        sel = 0;
        if (!m_busy && q.size() < DEPTH) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                c = (m_last + k) % NUM_CH;
                if (!acc && req_up[c]) begin
                    acc = 1'b1;
                    sel = c;
                end
            end
        end
        pop   = (q.size() != 0) && rec_ready;
        clr   = clear_stats;
        w     = packet_in[sel*DW +: DW];
        lat   = m_cyc[15:0] - w[21:6];
        r.id  = w[31:22];
        r.src = w[5:0];
        r.ch  = sel;
        r.lat = lat;

        @(posedge clk);
        #1;

        if (pop) void'(q.pop_front());
        if (acc) q.push_back(r);
        if (clr) begin
            m_cnt = acc ? 32'd1 : 32'd0;
            m_max = acc ? lat : 16'd0;
        end else if (acc) begin
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (lat > m_max) m_max = lat;
        end
        m_cyc  = m_cyc + 1;
        m_busy = acc;
        if (acc) m_last = sel;
        m_gnt = acc ? (4'b0001 << sel) : 4'b0000;

        chk("gnt_up", 32'(gnt_up), 32'(m_gnt));
        chk("up_full", 32'(up_full), (q.size() == DEPTH) ? 32'hF : 32'h0);
        chk("rec_valid", 32'(rec_valid), (q.size() != 0) ? 32'd1 : 32'd0);
        if (q.size() != 0) begin
            chk("rec_pkt_id", 32'(rec_pkt_id), q[0].id);
            chk("rec_src", 32'(rec_src), q[0].src);
            chk("rec_ch", 32'(rec_ch), q[0].ch);
            chk("rec_latency", 32'(rec_latency), q[0].lat);
        end
        chk("pkt_count", pkt_count, m_cnt);
        chk("max_latency", 32'(max_latency), 32'(m_max));
        chk("cycle_count", cycle_count, m_cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[$];
        int exp_order[5];
        int g;
        logic [15:0] t;

        exp_order = '{0, 1, 2, 3, 0};

        // Reset and single request at cycle_count=130.
        model_reset();
        do_reset();
        while (m_cyc != 130) tick();
        packet_in[0 +: DW] = mk(5, 100, 9);
        req_up = 4'b0001;
        tick();
        chk("single_gnt", 32'(gnt_up), 32'h1);
        chk("single_id", 32'(rec_pkt_id), 5);
        chk("single_src", 32'(rec_src), 9);
        chk("single_ch", 32'(rec_ch), 0);
        chk("single_lat", 32'(rec_latency), 30);
        chk("single_count", pkt_count, 1);
        req_up = 4'b0000;
        tick();
        chk("single_gnt_drop", 32'(gnt_up), 0);
        rec_ready = 1'b1;
        tick();
        rec_ready = 1'b0;

        // Fairness with all channels requesting.
        do_reset();
        req_up    = 4'b1111;
        rec_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_packets();
            tick();
            if (gnt_up != 0) order.push_back(gnt_idx(gnt_up));
        end
        chk("fair_count", order.size(), 5);
        for (int i = 0; i < 5 && i < order.size(); i++) begin
            chk("fair_order", order[i], exp_order[i]);
        end
        req_up = 4'b0000;
        tick();

        // Backpressure: consumer stalled, requests held.
        rec_ready = 1'b0;
        req_up    = 4'b1111;
        g = 0;
        for (int i = 0; i < 12; i++) begin
            rand_packets();
            tick();
            if (gnt_up != 0) g++;
        end
        chk("bp_accepted", g, 4);
        chk("bp_full", 32'(up_full), 32'hF);
        rec_ready = 1'b1;
        tick();
        chk("bp_no_grant_on_pop", 32'(gnt_up), 0);
        rec_ready = 1'b0;
        tick();
        chk("bp_fifth_grant", (gnt_up != 0) ? 32'd1 : 32'd0, 1);
        req_up    = 4'b0000;
        rec_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        rec_ready = 1'b0;

        // Timestamp wrap at cycle_count=5.
        do_reset();
        while (m_cyc != 5) tick();
        packet_in[0 +: DW] = mk(77, 16'hFFFE, 3);
        req_up = 4'b0001;
        tick();
        chk("wrap_lat", 32'(rec_latency), 7);
        chk("wrap_max", 32'(max_latency), 7);
        req_up = 4'b0000;
        tick();

        // Larger latency, then clear coincident with a push of latency 12.
        t = m_cyc[15:0] - 16'd50;
        packet_in[1*DW +: DW] = mk(88, t, 4);
        req_up = 4'b0010;
        tick();
        chk("pre_clear_max", 32'(max_latency), 50);
        req_up = 4'b0000;
        tick();
        t = m_cyc[15:0] - 16'd12;
        packet_in[2*DW +: DW] = mk(99, t, 11);
        req_up      = 4'b0100;
        clear_stats = 1'b1;
        tick();
        chk("clear_count", pkt_count, 1);
        chk("clear_max", 32'(max_latency), 12);
        clear_stats = 1'b0;
        req_up      = 4'b0000;
        rec_ready   = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rand_packets();
            req_up      = 4'($urandom_range(0, 15));
            rec_ready   = ($urandom_range(0, 3) != 0);
            clear_stats = ($urandom_range(0, 31) == 0);
            tick();
        end
        clear_stats = 1'b0;
        req_up      = 4'b0000;

        // Asynchronous reset in GRANT with two queued records.
        do_reset();
        rec_ready = 1'b0;
        rand_packets();
        req_up = 4'b0110;
        tick();
        tick();
        tick();
        chk("mid_grant_gnt", 32'(gnt_up), 32'h4);
        req_up = 4'b0000;
        #3;
        reset = 1'b0;
        #1;
        check_reset_state("mid_grant_reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        req_up = 4'b1111;
        tick();
        chk("post_reset_ch0", 32'(gnt_up), 32'h1);
        req_up = 4'b0000;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
